// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Arbiter states and the default anti-starvation streak limit.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_DSTREAK_DEF = 4;
  // Wide enough for the largest legal MAX_DSTREAK (15).
  localparam int unsigned STREAK_W        = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline ports, the arbiter and the shared memory bus.
// The master modport is the arbiter's view; slave is the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_done, i_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done, d_stall,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_done, i_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done, d_stall,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );

endinterface

// File: rtl/mem_port_arbiter_flopenrc.sv
// Resettable register with load enable and synchronous clear.
module mem_port_arbiter_flopenrc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_q <= '0;
    end else if (i_clr) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the fetch (I) and memory-stage (D) ports.
// D has priority; a streak counter forces an I grant after MAX_DSTREAK back-to-back D grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_DSTREAK);

  arb_state_e          r_state, w_state_nxt;
  logic [STREAK_W-1:0] r_streak, w_streak_nxt;
  logic                r_m_req, w_m_req_nxt;
  logic                r_i_done, w_i_done_nxt;
  logic                r_d_done, w_d_done_nxt;

  logic                w_i_elig, w_d_elig;
  logic                w_grant_i, w_grant_d, w_grant;
  logic                w_ack;
  logic                w_cap_i, w_cap_d;

  logic [ADDR_W-1:0]   w_m_addr, w_addr_sel;
  logic [DATA_W-1:0]   w_m_wdata, w_i_rdata, w_d_rdata;
  logic                w_m_we;

  // Done masks keep a requester from being re-granted in the cycle it sees its own done.
  assign w_i_elig = bus.i_req & ~r_i_done;
  assign w_d_elig = bus.d_req & ~r_d_done;
  assign w_ack    = bus.m_ack & r_m_req;
  assign w_grant  = w_grant_i | w_grant_d;

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_m_req_nxt  = r_m_req;
    w_i_done_nxt = 1'b0;
    w_d_done_nxt = 1'b0;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_cap_i      = 1'b0;
    w_cap_d      = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (w_d_elig && !(w_i_elig && (r_streak == StreakMax))) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ARB_DBUSY;
          w_m_req_nxt = 1'b1;
          if (bus.i_req) begin
            if (r_streak != StreakMax) begin
              w_streak_nxt = r_streak + 1'b1;
            end
          end else begin
            w_streak_nxt = '0;
          end
        end else if (w_i_elig) begin
          w_grant_i    = 1'b1;
          w_state_nxt  = ARB_IBUSY;
          w_m_req_nxt  = 1'b1;
          w_streak_nxt = '0;
        end
      end

      ARB_IBUSY: begin
        if (w_ack) begin
          w_state_nxt  = ARB_IDLE;
          w_m_req_nxt  = 1'b0;
          w_i_done_nxt = 1'b1;
          w_cap_i      = 1'b1;
        end
      end

      ARB_DBUSY: begin
        if (w_ack) begin
          w_state_nxt  = ARB_IDLE;
          w_m_req_nxt  = 1'b0;
          w_d_done_nxt = 1'b1;
          w_cap_d      = ~w_m_we;
        end
      end

      default: begin
        w_state_nxt = ARB_IDLE;
        w_m_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ARB_IDLE;
      r_streak <= '0;
      r_m_req  <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_m_req  <= w_m_req_nxt;
      r_i_done <= w_i_done_nxt;
      r_d_done <= w_d_done_nxt;
    end
  end

  assign w_addr_sel = w_grant_d ? bus.d_addr : bus.i_addr;

  mem_port_arbiter_flopenrc #(.WIDTH(ADDR_W)) u_m_addr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_grant),
    .i_clr (1'b0),
    .i_d   (w_addr_sel),
    .o_q   (w_m_addr)
  );

  // Fetch grants always read.
  mem_port_arbiter_flopenrc #(.WIDTH(1)) u_m_we (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_grant),
    .i_clr (1'b0),
    .i_d   (w_grant_d & bus.d_we),
    .o_q   (w_m_we)
  );

  mem_port_arbiter_flopenrc #(.WIDTH(DATA_W)) u_m_wdata (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_grant_d),
    .i_clr (1'b0),
    .i_d   (bus.d_wdata),
    .o_q   (w_m_wdata)
  );

  mem_port_arbiter_flopenrc #(.WIDTH(DATA_W)) u_i_rdata (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_cap_i),
    .i_clr (1'b0),
    .i_d   (bus.m_rdata),
    .o_q   (w_i_rdata)
  );

  mem_port_arbiter_flopenrc #(.WIDTH(DATA_W)) u_d_rdata (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_cap_d),
    .i_clr (1'b0),
    .i_d   (bus.m_rdata),
    .o_q   (w_d_rdata)
  );

  assign bus.m_req   = r_m_req;
  assign bus.m_we    = w_m_we;
  assign bus.m_addr  = w_m_addr;
  assign bus.m_wdata = w_m_wdata;
  assign bus.i_rdata = w_i_rdata;
  assign bus.d_rdata = w_d_rdata;
  assign bus.i_done  = r_i_done;
  assign bus.d_done  = r_d_done;
  assign bus.i_stall = bus.i_req & ~r_i_done;
  assign bus.d_stall = bus.d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of who owns the bus and what it was given.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_DSTREAK (MAXD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: owner of the bus (0 none, 1 fetch, 2 data) and the values handed to each party.
  int          mdl_owner;
  int          mdl_streak;
  logic        mdl_mreq, mdl_mwe, mdl_idone, mdl_ddone;
  logic [31:0] mdl_maddr, mdl_mwdata, mdl_irdata, mdl_drdata;

  task automatic model_reset();
    mdl_owner  = 0;
    mdl_streak = 0;
    mdl_mreq   = 1'b0;
    mdl_mwe    = 1'b0;
    mdl_idone  = 1'b0;
    mdl_ddone  = 1'b0;
    mdl_maddr  = '0;
    mdl_mwdata = '0;
    mdl_irdata = '0;
    mdl_drdata = '0;
  endtask

  task automatic model_step();
    bit want_i, want_d;
    int owner_was;
    owner_was = mdl_owner;
    want_i    = bus.i_req && !mdl_idone;
    want_d    = bus.d_req && !mdl_ddone;
    mdl_idone = 1'b0;
    mdl_ddone = 1'b0;
    if (owner_was == 0) begin
      if (want_d && !(want_i && mdl_streak == MAXD)) begin
        mdl_owner  = 2;
        mdl_mreq   = 1'b1;
        mdl_maddr  = bus.d_addr;
        mdl_mwe    = bus.d_we;
        mdl_mwdata = bus.d_wdata;
        mdl_streak = bus.i_req ? ((mdl_streak < MAXD) ? mdl_streak + 1 : MAXD) : 0;
      end else if (want_i) begin
        mdl_owner  = 1;
        mdl_mreq   = 1'b1;
        mdl_maddr  = bus.i_addr;
        mdl_mwe    = 1'b0;
        mdl_streak = 0;
      end
    end else if (bus.m_ack) begin
      mdl_owner = 0;
      mdl_mreq  = 1'b0;
      if (owner_was == 1) begin
        mdl_idone  = 1'b1;
        mdl_irdata = bus.m_rdata;
      end else begin
        mdl_ddone = 1'b1;
        if (!mdl_mwe) mdl_drdata = bus.m_rdata;
      end
    end
  endtask

  task automatic check_all();
    check("m_req",   32'(bus.m_req),  32'(mdl_mreq));
    check("m_we",    32'(bus.m_we),   32'(mdl_mwe));
    check("m_addr",  bus.m_addr,      mdl_maddr);
    check("m_wdata", bus.m_wdata,     mdl_mwdata);
    check("i_done",  32'(bus.i_done), 32'(mdl_idone));
    check("d_done",  32'(bus.d_done), 32'(mdl_ddone));
    check("i_rdata", bus.i_rdata,     mdl_irdata);
    check("d_rdata", bus.d_rdata,     mdl_drdata);
  endtask

  // Inputs are driven at posedge+1; stalls are sampled at negedge, registers at posedge+1.
  task automatic tick();
    @(negedge clk);
    check("i_stall", 32'(bus.i_stall), 32'(bus.i_req & ~mdl_idone));
    check("d_stall", 32'(bus.d_stall), 32'(bus.d_req & ~mdl_ddone));
    if (rst) model_step();
    else     model_reset();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
  endtask

  initial begin
    bit          i_drop, d_drop, prev_mreq;
    int          dcnt[2];
    int          round;
    logic [31:0] d_star_addr;

    idle_inputs();
    model_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Fetch alone: m_req the cycle after request, done the cycle after ack.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0040_0000;
    tick();
    check("ionly_mreq", 32'(bus.m_req), 32'd1);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h2408_000A;
    tick();
    check("ionly_done",  32'(bus.i_done), 32'd1);
    check("ionly_rdata", bus.i_rdata, 32'h2408_000A);
    bus.m_ack = 1'b0;
    tick();
    bus.i_req = 1'b0;
    tick();

    // Both request together: the store goes first, fetch follows after a one-cycle gap.
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0040_0004;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h1001_0004;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    check("sim_first_we",   32'(bus.m_we), 32'd1);
    check("sim_first_addr", bus.m_addr, 32'h1001_0004);
    bus.m_ack = 1'b1;
    tick();
    check("sim_ddone_first", {30'd0, bus.d_done, bus.i_done}, 32'd2);
    bus.m_ack = 1'b0;
    tick();
    bus.d_req = 1'b0;
    check("sim_i_addr", bus.m_addr, 32'h0040_0004);
    bus.m_ack = 1'b1;
    tick();
    check("sim_idone", 32'(bus.i_done), 32'd1);
    bus.m_ack = 1'b0;
    tick();
    bus.i_req = 1'b0;
    tick();

    // Spurious acks with nothing outstanding.
    bus.m_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("spur_nodone", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    end
    bus.m_ack = 1'b0;

    // Slow memory: bus outputs hold while the requester's inputs wander.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h1001_0008;
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
      bus.d_we    = 1'($urandom_range(0, 1));
      tick();
      check("lat_addr",  bus.m_addr, 32'h1001_0008);
      check("lat_we",    32'(bus.m_we), 32'd0);
      check("lat_stall", 32'(bus.d_stall), 32'd1);
    end
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h1234_5678;
    tick();
    check("lat_rdata", bus.d_rdata, 32'h1234_5678);
    bus.m_ack = 1'b0;
    tick();
    bus.d_req = 1'b0;
    tick();

    // Reset in the middle of a data access clears outputs without a clock edge.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h1001_000C;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_mreq",  32'(bus.m_req), 32'd0);
    check("rst_ddone", 32'(bus.d_done), 32'd0);
    check("rst_drdata", bus.d_rdata, 32'd0);
    model_reset();
    tick();
    rst = 1'b1;
    tick();
    check("rst_regrant", bus.m_addr, 32'h1001_000C);
    bus.m_ack = 1'b1;
    tick();
    bus.m_ack = 1'b0;
    tick();
    bus.d_req = 1'b0;
    tick();

    // Starvation guard: fetch is let through after exactly MAXD data grants, twice running.
    d_star_addr = 32'h1000_0100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = d_star_addr;
    bus.i_addr  = 32'h0040_0100;
    bus.m_ack   = 1'b1;
    dcnt[0] = 0;
    dcnt[1] = 0;
    round   = 0;
    for (int n = 0; n < 200 && round < 2; n++) begin
      bus.i_req = ~bus.d_done;
      prev_mreq = bus.m_req;
      tick();
      if (bus.m_req && !prev_mreq) begin
        if (bus.m_addr == d_star_addr) begin
          dcnt[round]++;
        end else begin
          check("starve_dcount", 32'(dcnt[round]), 32'(MAXD));
          round++;
        end
      end
    end
    check("starve_rounds", 32'(round), 32'd2);
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();

    // Random traffic with pipeline-like requesters and a random-latency memory.
    i_drop = 1'b0;
    d_drop = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (i_drop) begin
        i_drop     = 1'b0;
        bus.i_req  = ($urandom_range(0, 3) == 0);
        bus.i_addr = $urandom;
      end else if (bus.i_done) begin
        i_drop = 1'b1;
      end else if (!bus.i_req && $urandom_range(0, 2) == 0) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      if (d_drop) begin
        d_drop      = 1'b0;
        bus.d_req   = ($urandom_range(0, 3) == 0);
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end else if (bus.d_done) begin
        d_drop = 1'b1;
      end else if (!bus.d_req && $urandom_range(0, 1) == 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      bus.m_ack   = ($urandom_range(0, 2) == 0);
      bus.m_rdata = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
